// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_out;
  logic             rsp0_zero;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_out;
  logic             rsp1_zero;
  logic             rsp1_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_out, rsp1_zero, rsp1_err,
    output busy, op_count, dbg_state
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_out, rsp1_zero, rsp1_err,
    input  busy, op_count, dbg_state
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_OPCHK_EN to flag opcodes 4, 6, 7 as illegal (result 0, err 1).
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = 'x;
    case (alu_control)
      3'd0:    result = a + b;
      3'd1:    result = a - b;
      3'd2:    result = a & b;
      3'd3:    result = a | b;
      3'd5:    result = {31'b0, $signed(a) < $signed(b)};
      default: result = 'x;
    endcase
  end
  assign zero = (a == b);
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  alu_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             ill_q, ill_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [1:0]       zero_q, zero_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_id;
  logic             accept;
  logic [31:0]      alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] res_val;
  logic             zero_val;
  logic [1:0]       rsp_ready;

  // ALU only ever sees the latched operands, never the live request inputs.
  alu u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_res),
    .zero        (alu_zero)
  );

  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  // On a tie the requester that did not win last time goes first.
  assign gnt_id = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign accept = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);

  always_comb begin
`ifdef ALU_ARB_OPCHK_EN
    res_val  = ill_q ? '0 : alu_res;
    zero_val = ill_q ? 1'b0 : alu_zero;
`else
    res_val  = alu_res;
    zero_val = alu_zero;
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    ill_d        = ill_q;
    rsp_valid_d  = rsp_valid_q;
    out0_d       = out0_q;
    out1_d       = out1_q;
    zero_d       = zero_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = gnt_id ? bus.req1_a  : bus.req0_a;
          b_d          = gnt_id ? bus.req1_b  : bus.req0_b;
          op_d         = gnt_id ? bus.req1_op : bus.req0_op;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
`ifdef ALU_ARB_OPCHK_EN
          ill_d        = (op_d == 3'd4) || (op_d[2:1] == 2'b11);
`else
          ill_d        = 1'b0;
`endif
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (id_q) out1_d = res_val;
        else      out0_d = res_val;
        zero_d[id_q]      = zero_val;
        err_d[id_q]       = ill_q;
        rsp_valid_d[id_q] = 1'b1;
        state_d           = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[id_q]) begin
          rsp_valid_d[id_q] = 1'b0;
          cnt_d             = cnt_q + 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      ill_q        <= 1'b0;
      rsp_valid_q  <= '0;
      out0_q       <= '0;
      out1_q       <= '0;
      zero_q       <= '0;
      err_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      ill_q        <= ill_d;
      rsp_valid_q  <= rsp_valid_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_out   = out0_q;
  assign bus.rsp1_out   = out1_q;
  assign bus.rsp0_zero  = zero_q[0];
  assign bus.rsp1_zero  = zero_q[1];
  assign bus.rsp0_err   = err_q[0];
  assign bus.rsp1_err   = err_q[1];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.op_count   = cnt_q;
  assign bus.dbg_state  = state_q;
endmodule
